// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int unsigned PS2_EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Device responses and keyboard error codes that never become key events.
  function automatic logic ps2_is_ignored(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Key-event read port: show-ahead head fields with a valid/ready pop handshake.
interface ps2_evt_if;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       evt_valid;
  logic       evt_ready;

  modport master (output evt_code, evt_ext, evt_brk, evt_valid, input evt_ready);
  modport slave  (input evt_code, evt_ext, evt_brk, evt_valid, output evt_ready);
endinterface

// File: rtl/ps2_scancode_decoder_sync_fifo.sv
// Show-ahead synchronous FIFO; head data reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop_fire;
  logic             push_fire;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pop_fire  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_fire = push & (~full | pop_fire);
  assign rdata     = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: syncs the receiver strobe, strips prefixes, queues key events.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_err,
  ps2_evt_if.master            evt,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 clr_status
);
  localparam logic [2:0] S_IDLE    = 3'(IDLE);
  localparam logic [2:0] S_EXT     = 3'(EXT);
  localparam logic [2:0] S_BRK     = 3'(BRK);
  localparam logic [2:0] S_EXT_BRK = 3'(EXT_BRK);
  localparam logic [2:0] S_PAUSE   = 3'(PAUSE);

  logic       vld_s1, vld_s2, vld_s3;
  logic       err_s1, err_s2;
  logic       strobe_c;
  logic [7:0] byte_q;
  logic       err_q;
  logic       byte_stb;
  logic [2:0] state_q, state_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic       push_c;
  logic       err_evt_c;
  logic       drop_c;
  ps2_evt_t   evt_d;
  ps2_evt_t   head;
  logic       fifo_empty, fifo_full;

  // Valid chain resets high so a level already asserted at reset release is not a new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      {vld_s1, vld_s2, vld_s3} <= 3'b111;
      {err_s1, err_s2}         <= 2'b00;
    end else begin
      {vld_s1, vld_s2, vld_s3} <= {rx_valid, vld_s1, vld_s2};
      {err_s1, err_s2}         <= {rx_err, err_s1};
    end
  end

  assign strobe_c = vld_s2 & ~vld_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_stb <= 1'b0;
      byte_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      byte_stb <= strobe_c;
      if (strobe_c) begin
        byte_q <= rx_data;
        err_q  <= err_s2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    push_c    = 1'b0;
    err_evt_c = 1'b0;
    evt_d     = '{ext: 1'b0, brk: 1'b0, code: byte_q};
    if (byte_stb) begin
      if (err_q) begin
        state_d   = S_IDLE;
        pcnt_d    = '0;
        err_evt_c = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (byte_q == PS2_EXT) state_d = S_EXT;
            else if (byte_q == PS2_BRK) state_d = S_BRK;
            else if (byte_q == PS2_PAUSE) begin
              state_d = S_PAUSE;
              pcnt_d  = '0;
            end else if (!ps2_is_ignored(byte_q)) push_c = 1'b1;
          end
          S_EXT: begin
            if (byte_q == PS2_BRK) state_d = S_EXT_BRK;
            else if (byte_q != PS2_EXT) begin
              push_c    = 1'b1;
              evt_d.ext = 1'b1;
              state_d   = S_IDLE;
            end
          end
          S_BRK: begin
            push_c    = 1'b1;
            evt_d.brk = 1'b1;
            state_d   = S_IDLE;
          end
          S_EXT_BRK: begin
            push_c    = 1'b1;
            evt_d.ext = 1'b1;
            evt_d.brk = 1'b1;
            state_d   = S_IDLE;
          end
          S_PAUSE: begin
            // Pause is E1 plus seven fixed bytes; report it once as a single E1 make.
            if (pcnt_q == 3'd6) begin
              push_c     = 1'b1;
              evt_d.code = PS2_PAUSE;
              pcnt_d     = '0;
              state_d    = S_IDLE;
            end else begin
              pcnt_d = pcnt_q + 3'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  sync_fifo #(.WIDTH(PS2_EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (evt_d),
    .pop   (evt.evt_ready),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign evt.evt_code  = head.code;
  assign evt.evt_ext   = head.ext;
  assign evt.evt_brk   = head.brk;
  assign evt.evt_valid = ~fifo_empty;

  assign drop_c = push_c & fifo_full & ~(evt.evt_ready & ~fifo_empty);

  // A same-cycle event takes priority over clr_status.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (drop_c) overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;

      if (err_evt_c) begin
        if (clr_status) err_cnt <= ERR_CNT_W'(1);
        else if (!(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end else if (clr_status) begin
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised and directed bench for ps2_scancode_decoder against a byte-level behavioural model.
module tb_ps2_scancode_decoder;
  import ps2_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic       clr_status = 1'b0;
  logic       ready = 1'b0;
  logic       overflow;
  logic [7:0] err_cnt;
  bit         rand_mode = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  ps2_evt_if evt_if ();
  assign evt_if.evt_ready = ready;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .evt        (evt_if.master),
    .overflow   (overflow),
    .err_cnt    (err_cnt),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] b;
    logic       e;
    int         due;
  } pend_t;

  pend_t    pend[$];
  ps2_evt_t mq[$];
  int       cyc = 0;
  logic     m_prev = 1'b1;
  logic     m_ext = 1'b0, m_brk = 1'b0;
  int       m_pause = 0;
  logic     m_ovf = 1'b0;
  int       m_err = 0;

  function automatic void decode(input logic [7:0] b, input logic e,
                                 output bit has_evt, output ps2_evt_t ev, output bit is_err);
    has_evt = 0;
    is_err  = 0;
    ev      = '0;
    if (e) begin
      is_err = 1; m_ext = 0; m_brk = 0; m_pause = 0;
    end else if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin has_evt = 1; ev = '{1'b0, 1'b0, 8'hE1}; end
    end else if (m_brk) begin
      has_evt = 1; ev = '{m_ext, 1'b1, b}; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE1 && !m_ext) begin
      m_pause = 7;
    end else if (!m_ext && (b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                            b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
      has_evt = 0;
    end else begin
      has_evt = 1; ev = '{m_ext, 1'b0, b}; m_ext = 0;
    end
  endfunction

  // A byte rising at edge c is decoded and queued at edge c+3.
  always @(posedge clk) begin
    bit       pop_now, has_evt, is_err, drop;
    ps2_evt_t ev;
    pend_t    p;
    int       sz;
    cyc++;
    if (rst) begin
      pend.delete(); mq.delete();
      m_prev = 1; m_ext = 0; m_brk = 0; m_pause = 0; m_ovf = 0; m_err = 0;
    end else begin
      has_evt = 0; is_err = 0; drop = 0;
      sz      = mq.size();
      pop_now = ready && (sz > 0);
      if (rx_valid && !m_prev) pend.push_back('{rx_data, rx_err, cyc + 3});
      m_prev = rx_valid;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        decode(p.b, p.e, has_evt, ev, is_err);
      end
      if (pop_now) void'(mq.pop_front());
      if (has_evt) begin
        if (sz < DEPTH || pop_now) mq.push_back(ev);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clr_status) m_ovf = 0;
      if (is_err) m_err = clr_status ? 1 : ((m_err < 255) ? m_err + 1 : 255);
      else if (clr_status) m_err = 0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    ps2_evt_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("m_evt_valid", {31'd0, evt_if.evt_valid}, {31'd0, mq.size() > 0});
    chk("m_evt_code",  {24'd0, evt_if.evt_code}, {24'd0, h.code});
    chk("m_evt_ext",   {31'd0, evt_if.evt_ext}, {31'd0, h.ext});
    chk("m_evt_brk",   {31'd0, evt_if.evt_brk}, {31'd0, h.brk});
    chk("m_overflow",  {31'd0, overflow}, {31'd0, m_ovf});
    chk("m_err_cnt",   {24'd0, err_cnt}, m_err);
  end

  always @(negedge clk) begin
    if (rand_mode) begin
      ready      = 1'($urandom_range(1, 0));
      clr_status = ($urandom_range(31, 0) == 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input logic e);
    @(negedge clk);
    rx_data = b; rx_err = e; rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0; rx_err = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] c, input logic x, input logic k);
    chk({nm, "_valid"}, {31'd0, evt_if.evt_valid}, 32'd1);
    chk({nm, "_code"},  {24'd0, evt_if.evt_code}, {24'd0, c});
    chk({nm, "_ext"},   {31'd0, evt_if.evt_ext}, {31'd0, x});
    chk({nm, "_brk"},   {31'd0, evt_if.evt_brk}, {31'd0, k});
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
  endtask

  initial begin
    logic [7:0] pause_seq [9];
    logic [7:0] b;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
    chk("rst_code", {24'd0, evt_if.evt_code}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Latency: one-cycle event exactly 4 edges after the rise.
    ready = 1'b1;
    @(negedge clk); rx_data = 8'h1C; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_early", {31'd0, evt_if.evt_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, evt_if.evt_valid}, 32'd1);
    chk("lat_code", {24'd0, evt_if.evt_code}, 32'h1C);
    chk("lat_flags", {30'd0, evt_if.evt_ext, evt_if.evt_brk}, 32'd0);
    @(negedge clk);
    chk("lat_gone", {31'd0, evt_if.evt_valid}, 32'd0);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    ready = 1'b0;

    // Extended break.
    send(8'hE0, 0); send(8'hF0, 0); send(8'h74, 0);
    pop_chk("extbrk", 8'h74, 1, 1);
    chk("extbrk_only", {31'd0, evt_if.evt_valid}, 32'd0);

    // Pause sequence then a make.
    foreach (pause_seq[i]) send(pause_seq[i], 0);
    pop_chk("pause", 8'hE1, 0, 0);
    pop_chk("after_pause", 8'h1C, 0, 0);
    chk("pause_only", {31'd0, evt_if.evt_valid}, 32'd0);

    // Overflow on the ninth event.
    for (int i = 1; i <= 9; i++) send(8'(i), 0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) pop_chk("ovf_drain", 8'(i), 0, 0);
    chk("ovf_empty", {31'd0, evt_if.evt_valid}, 32'd0);
    pulse_clr();
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Error mid-prefix, then saturation.
    send(8'hE0, 0); send(8'h55, 1); send(8'h75, 0);
    chk("err_one", {24'd0, err_cnt}, 32'd1);
    pop_chk("err_after", 8'h75, 0, 0);
    for (int i = 0; i < 256; i++) send(8'h33, 1);
    chk("err_sat", {24'd0, err_cnt}, 32'hFF);
    pulse_clr();
    chk("err_clr", {24'd0, err_cnt}, 32'd0);

    // Error coinciding with clr_status wins.
    send(8'h33, 1); send(8'h33, 1);
    @(negedge clk); rx_data = 8'h33; rx_err = 1'b1; rx_valid = 1'b1;
    repeat (3) @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    chk("err_clr_race", {24'd0, err_cnt}, 32'd1);
    rx_valid = 1'b0; rx_err = 1'b0;
    repeat (4) @(negedge clk);

    // rx_valid high across reset release.
    @(negedge clk); rst = 1'b1; rx_data = 8'h1C; rx_valid = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk); rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_hold_noevt", {31'd0, evt_if.evt_valid}, 32'd0);

    // Reset mid-sequence loses the prefix.
    send(8'hE0, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    send(8'h75, 0);
    pop_chk("rst_mid", 8'h75, 0, 0);

    // Push and pop together while full.
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    chk("full_noovf", {31'd0, overflow}, 32'd0);
    @(negedge clk); rx_data = 8'h42; rx_valid = 1'b1;
    repeat (3) @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    chk("pp_noovf", {31'd0, overflow}, 32'd0);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 2; i <= 8; i++) pop_chk("pp_drain", 8'(i), 0, 0);
    pop_chk("pp_last", 8'h42, 0, 0);
    chk("pp_empty", {31'd0, evt_if.evt_valid}, 32'd0);

    // Random traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(9, 0))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        3: begin
          b = 8'hAA;
          case ($urandom_range(5, 0))
            0: b = 8'hFA;
            1: b = 8'hEE;
            2: b = 8'hFE;
            3: b = 8'h00;
            4: b = 8'hFF;
            default: b = 8'hAA;
          endcase
        end
        default: b = 8'($urandom_range(255, 0));
      endcase
      send(b, $urandom_range(15, 0) == 0);
    end
    rand_mode = 1'b0;
    @(negedge clk); ready = 1'b1; clr_status = 1'b0;
    repeat (20) @(negedge clk);
    chk("rand_drained", {31'd0, evt_if.evt_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
